// File: rtl/wb_gpio_bank.sv
// Wishbone GPIO bank: output/direction registers, synchronised pad inputs and
// per-pin edge interrupts (rising or falling) with sticky W1C status.
module wb_gpio_bank #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [4:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq_o
);

  localparam logic [2:0] REG_IN    = 3'd0;
  localparam logic [2:0] REG_OUT   = 3'd1;
  localparam logic [2:0] REG_DIR   = 3'd2;
  localparam logic [2:0] REG_IEN   = 3'd3;
  localparam logic [2:0] REG_IMODE = 3'd4;
  localparam logic [2:0] REG_ISTAT = 3'd5;
  localparam logic [2:0] REG_OSET  = 3'd6;
  localparam logic [2:0] REG_OCLR  = 3'd7;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  logic                 ack_q, ack_d;
  logic [31:0]          dat_q, dat_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [WIDTH-1:0]     dir_q, dir_d;
  logic [WIDTH-1:0]     ien_q, ien_d;
  logic [WIDTH-1:0]     imode_q, imode_d;
  logic [WIDTH-1:0]     istat_q, istat_d;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_d [SYNC_STAGES];
  logic [SYNC_STAGES:0] fill_q, fill_d;

  logic             req_s, wr_s, rd_s, evt_en_s;
  logic [2:0]       reg_s;
  logic [31:0]      mask_s, rdata_s;
  logic [WIDTH-1:0] wmask_s, wbits_s, last_s, evt_s, istat_clr_s;
  logic [1:0]       unused_adr_s;

  assign req_s        = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_s         = req_s & wb_we_i;
  assign rd_s         = req_s & ~wb_we_i;
  assign reg_s        = wb_adr_i[4:2];
  assign unused_adr_s = wb_adr_i[1:0];
  assign mask_s       = sel_to_mask(wb_sel_i);
  assign wmask_s      = mask_s[WIDTH-1:0];
  assign wbits_s      = wb_dat_i[WIDTH-1:0] & wmask_s;
  assign last_s       = sync_q[SYNC_STAGES-1];

  // Events stay gated until prev holds real pad data after reset, so a pad
  // already high at release refills silently; an IMODE write also masks them.
  always_comb begin
    sync_d[0] = gpio_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d   = last_s;
    fill_d   = {fill_q[SYNC_STAGES-1:0], 1'b1};
    evt_en_s = fill_q[SYNC_STAGES] & ~(wr_s && (reg_s == REG_IMODE));
    if (evt_en_s) begin
      evt_s = (imode_q & ~last_s & prev_q) | (~imode_q & last_s & ~prev_q);
    end else begin
      evt_s = '0;
    end
  end

  always_comb begin
    out_d       = out_q;
    dir_d       = dir_q;
    ien_d       = ien_q;
    imode_d     = imode_q;
    istat_clr_s = '0;
    if (wr_s) begin
      case (reg_s)
        REG_OUT:   out_d       = (out_q & ~wmask_s) | wbits_s;
        REG_DIR:   dir_d       = (dir_q & ~wmask_s) | wbits_s;
        REG_IEN:   ien_d       = (ien_q & ~wmask_s) | wbits_s;
        REG_IMODE: imode_d     = (imode_q & ~wmask_s) | wbits_s;
        REG_ISTAT: istat_clr_s = wbits_s;
        REG_OSET:  out_d       = out_q | wbits_s;
        REG_OCLR:  out_d       = out_q & ~wbits_s;
        default:   out_d       = out_q;
      endcase
    end else begin
      out_d = out_q;
    end
    // A new event outranks a simultaneous clear.
    istat_d = (istat_q & ~istat_clr_s) | evt_s;
  end

  always_comb begin
    rdata_s = 32'h0000_0000;
    case (reg_s)
      REG_IN:    rdata_s[WIDTH-1:0] = last_s;
      REG_OUT:   rdata_s[WIDTH-1:0] = out_q;
      REG_DIR:   rdata_s[WIDTH-1:0] = dir_q;
      REG_IEN:   rdata_s[WIDTH-1:0] = ien_q;
      REG_IMODE: rdata_s[WIDTH-1:0] = imode_q;
      REG_ISTAT: rdata_s[WIDTH-1:0] = istat_q;
      default:   rdata_s = 32'h0000_0000;
    endcase
    ack_d = req_s;
    if (rd_s) begin
      dat_d = rdata_s;
    end else begin
      dat_d = 32'h0000_0000;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'h0000_0000;
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      imode_q <= '0;
      istat_q <= '0;
      prev_q  <= '0;
      fill_q  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      imode_q <= imode_d;
      istat_q <= istat_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign gpio_o   = out_q;
  assign gpio_oe  = dir_q;
  assign irq_o    = |(istat_q & ien_q);

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank: a 32-pin and an 8-pin instance,
// expected values queued when stimulus is issued and popped on DUT response.
module tb_wb_gpio_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  logic        we, cyc, stb_a, stb_b;
  logic [31:0] dat_a, dat_b;
  logic        ack_a, ack_b, irq_a, irq_b;
  logic [31:0] gpio_i, gpio_o, gpio_oe;
  logic [7:0]  gpio8_i, gpio8_o, gpio8_oe;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  wb_gpio_bank #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb_a),
    .wb_dat_o(dat_a), .wb_ack_o(ack_a),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq_o(irq_a)
  );

  wb_gpio_bank #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb_b),
    .wb_dat_o(dat_b), .wb_ack_o(ack_b),
    .gpio_i(gpio8_i), .gpio_o(gpio8_o), .gpio_oe(gpio8_oe), .irq_o(irq_b)
  );

  task automatic wb_xfer(input bit b, input logic [4:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit w,
                         output logic [31:0] rd, output bit ok);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1;
    if (b) stb_b = 1'b1;
    else   stb_a = 1'b1;
    ok = 1'b0;
    rd = 32'h0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(posedge clk); #1;
      if ((b ? ack_b : ack_a) === 1'b1) begin
        ok = 1'b1;
        rd = b ? dat_b : dat_a;
      end
    end
    cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input bit b, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] rd;
    bit ok;
    wb_xfer(b, a, d, s, 1'b1, rd, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_ack: adr %h got no ack, required ack within 8 cycles", a);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd, exp;
    bit ok;
    checks++;
    if ({ack_a, irq_a, dat_a, gpio_o, gpio_oe} !== 98'h0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b irq=%b dat=%h o=%h oe=%h, required all 0",
               ack_a, irq_a, dat_a, gpio_o, gpio_oe);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(32'h0);
      wb_xfer(1'b0, 5'(i * 4), 32'h0, 4'hF, 1'b0, rd, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %h ack=%0d, required %h", i, rd, ok, exp);
      end
    end
  endtask

  task automatic test_out_regs();
    logic [31:0] rd, exp;
    logic [4:0]  ra [4];
    bit ok;
    wb_write(1'b0, 5'h04, 32'h1234_56FF, 4'b0001);
    wb_write(1'b0, 5'h18, 32'h0000_0100, 4'hF);
    wb_write(1'b0, 5'h1C, 32'h0000_0001, 4'hF);
    wb_write(1'b0, 5'h08, 32'hFFFF_FFFF, 4'b0010);
    wb_write(1'b0, 5'h08, 32'hAAAA_AA0F, 4'b0001);
    ra = '{5'h04, 5'h08, 5'h18, 5'h1C};
    exp_q.push_back(32'h0000_01FE);
    exp_q.push_back(32'h0000_FF0F);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, ra[i], 32'h0, 4'hF, 1'b0, rd, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
        errors++;
        $display("FAIL out_regs_read[%0d]: got %h ack=%0d, required %h", i, rd, ok, exp);
      end
    end
    checks++;
    if (gpio_o !== 32'h0000_01FE || gpio_oe !== 32'h0000_FF0F) begin
      errors++;
      $display("FAIL pads: gpio_o=%h gpio_oe=%h, required 000001fe 0000ff0f", gpio_o, gpio_oe);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd, exp;
    logic [4:0]  ra [6];
    logic [3:0]  ws [6];
    bit ok;
    wb_write(1'b0, 5'h0C, 32'h0000_0008, 4'hF);
    @(negedge clk);
    gpio_i[3] = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      checks++;
      if ({31'h0, irq_a} !== exp) begin
        errors++;
        $display("FAIL irq_latency[%0d]: irq=%b, required %0d", i, irq_a, exp);
      end
    end
    exp_q.push_back(32'h0000_0008);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL istat_set: got %h ack=%0d, required %h", rd, ok, exp);
    end
    wb_write(1'b0, 5'h14, 32'h0000_0008, 4'hF);
    checks++;
    if (irq_a !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear: irq=%b, required 0", irq_a);
    end
    // Bit 3 falls (rising mode: ignored); bit 9 rises with IEN[9]=0, DIR[9]=1.
    @(negedge clk);
    gpio_i = 32'h0000_0200;
    repeat (5) @(posedge clk);
    #1;
    ra = '{5'h00, 5'h14, 5'h14, 5'h14, 5'h14, 5'h14};
    ws = '{4'h0, 4'h0, 4'b0001, 4'h0, 4'b0010, 4'h0};
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0000_0200);
    exp_q.push_back(32'h0);
    for (int i = 0; i < 6; i++) begin
      if (ws[i] != 4'h0) begin
        wb_write(1'b0, ra[i], 32'h0000_0200, ws[i]);
      end else begin
        wb_xfer(1'b0, ra[i], 32'h0, 4'hF, 1'b0, rd, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || rd !== exp) begin
          errors++;
          $display("FAIL irq_status[%0d]: got %h ack=%0d, required %h", i, rd, ok, exp);
        end
        if (i == 1) begin
          checks++;
          if (irq_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked: irq=%b, required 0", irq_a);
          end
        end
      end
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd, exp;
    bit ok;
    wb_write(1'b0, 5'h10, 32'h0000_0020, 4'hF);
    @(negedge clk);
    gpio_i[5] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL falling_mode_rise: got %h ack=%0d, required %h", rd, ok, exp);
    end
    @(negedge clk);
    gpio_i[5] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    wb_write(1'b0, 5'h14, 32'h0000_0020, 4'hF);
    exp_q.push_back(32'h0000_0020);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL w1c_race: got %h ack=%0d, required %h", rd, ok, exp);
    end
    wb_write(1'b0, 5'h14, 32'h0000_0020, 4'hF);
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL w1c_after_race: got %h ack=%0d, required %h", rd, ok, exp);
    end
  endtask

  task automatic test_width8();
    logic [31:0] rd, exp;
    logic [4:0]  ra [4];
    bit ok;
    @(negedge clk);
    gpio8_i = 8'h3C;
    wb_write(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF);
    wb_write(1'b1, 5'h04, 32'h1234_56A5, 4'hF);
    ra = '{5'h08, 5'h1C, 5'h04, 5'h00};
    exp_q.push_back(32'h0000_00FF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_00A5);
    exp_q.push_back(32'h0000_003C);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b1, ra[i], 32'h0, 4'hF, 1'b0, rd, ok);
      exp = exp_q.pop_front();
      checks++;
      if (!ok || rd !== exp) begin
        errors++;
        $display("FAIL width8_read[%0d]: got %h ack=%0d, required %h", i, rd, ok, exp);
      end
    end
    checks++;
    if (gpio8_oe !== 8'hFF || gpio8_o !== 8'hA5) begin
      errors++;
      $display("FAIL width8_pads: oe=%h o=%h, required ff a5", gpio8_oe, gpio8_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, exp;
    bit ok;
    @(negedge clk);
    gpio_i = 32'h0;
    adr = 5'h04; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb_a = 1'b1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) #1;
      else begin
        @(posedge clk); #1;
      end
      exp = exp_q.pop_front();
      checks++;
      if ({31'h0, ack_a} !== exp) begin
        errors++;
        $display("FAIL ack_pattern[%0d]: ack=%b, required %0d", i, ack_a, exp);
      end
    end
    cyc = 1'b0; stb_a = 1'b0;
    // Reset lands in the same cycle as a pending write: no ack, no update.
    @(negedge clk);
    adr = 5'h04; wdat = 32'hDEAD_BEEF; we = 1'b1; cyc = 1'b1; stb_a = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack_a !== 1'b0 || gpio_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort: ack=%b gpio_o=%h, required 0 00000000", ack_a, gpio_o);
    end
    @(negedge clk);
    cyc = 1'b0; stb_a = 1'b0; we = 1'b0;
    rst = 1'b0;
    exp_q.push_back(32'h0);
    wb_xfer(1'b0, 5'h04, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL abort_out: got %h ack=%0d, required %h", rd, ok, exp);
    end
    wb_write(1'b0, 5'h04, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back(32'hDEAD_BEEF);
    wb_xfer(1'b0, 5'h04, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL reissue_out: got %h ack=%0d, required %h", rd, ok, exp);
    end
  endtask

  task automatic test_reset_level();
    logic [31:0] rd, exp;
    bit ok;
    @(negedge clk);
    rst = 1'b1;
    gpio_i = 32'h0000_0080;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0080);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL level_at_release: istat %h ack=%0d, required %h", rd, ok, exp);
    end
    wb_xfer(1'b0, 5'h00, 32'h0, 4'hF, 1'b0, rd, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || rd !== exp) begin
      errors++;
      $display("FAIL in_after_release: got %h ack=%0d, required %h", rd, ok, exp);
    end
  endtask

  initial begin
    rst = 1'b1; adr = 5'h0; wdat = 32'h0; sel = 4'h0; we = 1'b0;
    cyc = 1'b0; stb_a = 1'b0; stb_b = 1'b0;
    gpio_i = 32'h0; gpio8_i = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_out_regs();
    test_irq();
    test_w1c_race();
    test_width8();
    test_back_to_back();
    test_reset_level();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, required completion");
    $fatal(1);
  end

endmodule
